// File: rtl/mips_pkg.sv
// mips_pkg: shared decode definitions for the MIPS pipeline.
//   - opcode / funct constants for the supported instruction subset
//   - ALU operation, writeback-select and immediate-mode enums
//   - ctrl_t control bundle carried down the pipeline, and its width CTRL_W
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // AluAdd is zero so an all-zero ctrl bundle is a clean NOP.
  typedef enum logic [3:0] {
    AluAdd, AluAddu, AluSub, AluSubu, AluAnd, AluOr, AluXor, AluNor,
    AluSlt, AluSltu, AluSll, AluSrl, AluSra, AluLui
  } alu_op_e;

  typedef enum logic [1:0] {WselNone, WselRd, WselRt} wsel_e;

  typedef enum logic [1:0] {ImmSign, ImmZero, ImmLui} imm_mode_e;

  typedef struct packed {
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       alusrc;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic [3:0] aluop;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

  // ALU operation for the immediate-ALU opcodes.
  function automatic alu_op_e imm_alu_op(logic [5:0] op);
    alu_op_e r;
    case (op)
      OP_ADDIU: r = AluAddu;
      OP_SLTI:  r = AluSlt;
      OP_ANDI:  r = AluAnd;
      OP_ORI:   r = AluOr;
      OP_XORI:  r = AluXor;
      OP_LUI:   r = AluLui;
      default:  r = AluAdd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_ctrl_dec.sv
// id_ctrl_dec: purely combinational control decoder.
// Ports:
//   opcode, funct  in   instruction opcode and R-type funct fields
//   ctrl           out  ctrl_t bundle (all zero for unsupported encodings)
//   waddrSel       out  destination select (wsel_e: none / rd / rt)
//   immMode        out  immediate extension mode (imm_mode_e)
//   usesRt         out  instruction reads rt as a source operand
module id_ctrl_dec
  import mips_pkg::*;
(
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  output logic [CTRL_W-1:0] ctrl,
  output logic [1:0]        waddrSel,
  output logic [1:0]        immMode,
  output logic              usesRt
);

  ctrl_t     c;
  wsel_e     ws;
  imm_mode_e im;
  alu_op_e   rOp;
  logic      rKnown;

  always_comb begin
    rKnown = 1'b1;
    rOp    = AluAdd;
    case (funct)
      FN_ADD:  rOp = AluAdd;
      FN_ADDU: rOp = AluAddu;
      FN_SUB:  rOp = AluSub;
      FN_SUBU: rOp = AluSubu;
      FN_AND:  rOp = AluAnd;
      FN_OR:   rOp = AluOr;
      FN_XOR:  rOp = AluXor;
      FN_NOR:  rOp = AluNor;
      FN_SLT:  rOp = AluSlt;
      FN_SLTU: rOp = AluSltu;
      FN_SLL:  rOp = AluSll;
      FN_SRL:  rOp = AluSrl;
      FN_SRA:  rOp = AluSra;
      default: rKnown = 1'b0;
    endcase
  end

  always_comb begin
    c      = '0;
    ws     = WselNone;
    im     = ImmSign;
    usesRt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        usesRt = 1'b1;
        // Unsupported funct values stay a NOP.
        if (rKnown) begin
          c.regwrite = 1'b1;
          c.aluop    = rOp;
          ws         = WselRd;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        c.regwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = imm_alu_op(opcode);
        ws         = WselRt;
        if (opcode == OP_LUI) begin
          im = ImmLui;
        end else if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI) begin
          im = ImmZero;
        end
      end
      OP_LW: begin
        c.regwrite = 1'b1;
        c.memread  = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = AluAdd;
        ws         = WselRt;
      end
      OP_SW: begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.aluop    = AluAdd;
        usesRt     = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        c.branch    = 1'b1;
        c.branch_ne = (opcode == OP_BNE);
        c.aluop     = AluSub;
        usesRt      = 1'b1;
      end
      OP_J: begin
        c.jump = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl     = c;
  assign waddrSel = ws;
  assign immMode  = im;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/operand stage and ID/EX pipeline register.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_valid, id_instr, id_pc IF/ID contents (id_pc is PC+4)
//   rf_raddr1/2, rf_rdata1/2  register file read ports (addresses combinational)
//   wb_regwrite/waddr/wdata   writeback port, bypassed into same-cycle operands
//   ex_hold, ex_flush         EX back-pressure and taken-branch squash
//   stall_out                 hold PC and IF/ID (combinational)
//   ex_*                      registered ID/EX contents
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [XLEN-1:0]   id_pc,
  output logic [4:0]        rf_raddr1,
  output logic [4:0]        rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_waddr,
  input  logic [XLEN-1:0]   wb_wdata,
  input  logic              ex_hold,
  input  logic              ex_flush,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs_val,
  output logic [XLEN-1:0]   ex_rt_val,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_waddr,
  output logic [CTRL_W-1:0] ex_ctrl
);

  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic        unusedShamt;

  assign rs          = id_instr[25:21];
  assign rt          = id_instr[20:16];
  assign rd          = id_instr[15:11];
  assign imm16       = id_instr[15:0];
  assign unusedShamt = ^id_instr[10:6];

  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  logic [CTRL_W-1:0] decCtrlBits;
  logic [1:0]        waddrSel;
  logic [1:0]        immMode;
  logic              usesRt;
  ctrl_t             decCtrl;

  id_ctrl_dec u_dec (
    .opcode   (id_instr[31:26]),
    .funct    (id_instr[5:0]),
    .ctrl     (decCtrlBits),
    .waddrSel (waddrSel),
    .immMode  (immMode),
    .usesRt   (usesRt)
  );

  assign decCtrl = decCtrlBits;

  // Operands: $0 is hard zero; otherwise the writeback value wins over the
  // register file because the file only updates at the end of this cycle.
  logic [XLEN-1:0] rsVal, rtVal, immVal;
  logic [4:0]      waddr;

  always_comb begin
    rsVal = rf_rdata1;
    rtVal = rf_rdata2;
    if (rs == 5'd0) begin
      rsVal = '0;
    end else if (wb_regwrite && wb_waddr == rs) begin
      rsVal = wb_wdata;
    end
    if (rt == 5'd0) begin
      rtVal = '0;
    end else if (wb_regwrite && wb_waddr == rt) begin
      rtVal = wb_wdata;
    end
  end

  always_comb begin
    immVal = XLEN'($signed(imm16));
    if (immMode == ImmZero) begin
      immVal = XLEN'(imm16);
    end else if (immMode == ImmLui) begin
      immVal = XLEN'({imm16, 16'h0000});
    end
  end

  always_comb begin
    waddr = 5'd0;
    if (waddrSel == WselRd) begin
      waddr = rd;
    end else if (waddrSel == WselRt) begin
      waddr = rt;
    end
  end

  // ID/EX register
  logic            exValid_q, exValid_d;
  logic [XLEN-1:0] exPc_q, exPc_d;
  logic [XLEN-1:0] exRsVal_q, exRsVal_d;
  logic [XLEN-1:0] exRtVal_q, exRtVal_d;
  logic [XLEN-1:0] exImm_q, exImm_d;
  logic [4:0]      exRs_q, exRs_d;
  logic [4:0]      exRt_q, exRt_d;
  logic [4:0]      exWaddr_q, exWaddr_d;
  ctrl_t           exCtrl_q, exCtrl_d;

  logic loadUse;

  assign loadUse = id_valid && exValid_q && exCtrl_q.memread && (exWaddr_q != 5'd0) &&
                   ((exWaddr_q == rs) || (usesRt && exWaddr_q == rt));

  // A flush kills the dependent instruction, so there is nothing to wait for.
  assign stall_out = ex_hold || (loadUse && !ex_flush);

  always_comb begin
    exValid_d = exValid_q;
    exPc_d    = exPc_q;
    exRsVal_d = exRsVal_q;
    exRtVal_d = exRtVal_q;
    exImm_d   = exImm_q;
    exRs_d    = exRs_q;
    exRt_d    = exRt_q;
    exWaddr_d = exWaddr_q;
    exCtrl_d  = exCtrl_q;
    if (ex_hold) begin
      // Keep everything; a concurrent flush is re-issued by EX after the hold.
    end else if (ex_flush || loadUse) begin
      exValid_d = 1'b0;
      exPc_d    = '0;
      exRsVal_d = '0;
      exRtVal_d = '0;
      exImm_d   = '0;
      exRs_d    = 5'd0;
      exRt_d    = 5'd0;
      exWaddr_d = 5'd0;
      exCtrl_d  = '0;
    end else begin
      exValid_d = id_valid;
      exPc_d    = id_pc;
      exRsVal_d = rsVal;
      exRtVal_d = rtVal;
      exImm_d   = immVal;
      exRs_d    = rs;
      exRt_d    = rt;
      exWaddr_d = waddr;
      exCtrl_d  = id_valid ? decCtrl : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exValid_q <= 1'b0;
      exPc_q    <= RESET_PC;
      exRsVal_q <= '0;
      exRtVal_q <= '0;
      exImm_q   <= '0;
      exRs_q    <= 5'd0;
      exRt_q    <= 5'd0;
      exWaddr_q <= 5'd0;
      exCtrl_q  <= '0;
    end else begin
      exValid_q <= exValid_d;
      exPc_q    <= exPc_d;
      exRsVal_q <= exRsVal_d;
      exRtVal_q <= exRtVal_d;
      exImm_q   <= exImm_d;
      exRs_q    <= exRs_d;
      exRt_q    <= exRt_d;
      exWaddr_q <= exWaddr_d;
      exCtrl_q  <= exCtrl_d;
    end
  end

  assign ex_valid  = exValid_q;
  assign ex_pc     = exPc_q;
  assign ex_rs_val = exRsVal_q;
  assign ex_rt_val = exRtVal_q;
  assign ex_imm    = exImm_q;
  assign ex_rs     = exRs_q;
  assign ex_rt     = exRt_q;
  assign ex_waddr  = exWaddr_q;
  assign ex_ctrl   = exCtrl_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              id_valid = 1'b0;
  logic [31:0]       id_instr = '0;
  logic [31:0]       id_pc = '0;
  logic [4:0]        rf_raddr1, rf_raddr2;
  logic [31:0]       rf_rdata1 = '0, rf_rdata2 = '0;
  logic              wb_regwrite = 1'b0;
  logic [4:0]        wb_waddr = '0;
  logic [31:0]       wb_wdata = '0;
  logic              ex_hold = 1'b0, ex_flush = 1'b0;
  logic              stall_out, ex_valid;
  logic [31:0]       ex_pc, ex_rs_val, ex_rt_val, ex_imm;
  logic [4:0]        ex_rs, ex_rt, ex_waddr;
  logic [CTRL_W-1:0] ex_ctrl;

  id_ex_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_regwrite(wb_regwrite), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ex_hold(ex_hold), .ex_flush(ex_flush), .stall_out(stall_out), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_waddr(ex_waddr), .ex_ctrl(ex_ctrl)
  );

  always #5 clk = ~clk;

  // Expected ID/EX contents; full=0 marks a bubble whose data fields are don't-care.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rsv, rtv, imm;
    logic [4:0]  rs, rt, wa;
    ctrl_t       ctrl;
    logic        full;
  } exp_t;

  exp_t sbq[$];
  exp_t m;
  int   checks = 0;
  int   failures = 0;
  bit   modelKnown = 1'b0;
  logic lastStall = 1'b0;
  logic seenStall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode written straight from the instruction-set rules.
  function automatic void ref_decode(input logic [31:0] ins, output ctrl_t c,
                                     output logic [4:0] wa, output logic [31:0] imm,
                                     output logic ur);
    logic [5:0] op, fn;
    op  = ins[31:26];
    fn  = ins[5:0];
    c   = '0;
    wa  = 5'd0;
    ur  = 1'b0;
    imm = {{16{ins[15]}}, ins[15:0]};
    if (op == OP_RTYPE) begin
      ur = 1'b1;
      c.regwrite = 1'b1;
      wa = ins[15:11];
      case (fn)
        FN_ADD:  c.aluop = AluAdd;
        FN_ADDU: c.aluop = AluAddu;
        FN_SUB:  c.aluop = AluSub;
        FN_SUBU: c.aluop = AluSubu;
        FN_AND:  c.aluop = AluAnd;
        FN_OR:   c.aluop = AluOr;
        FN_XOR:  c.aluop = AluXor;
        FN_NOR:  c.aluop = AluNor;
        FN_SLT:  c.aluop = AluSlt;
        FN_SLTU: c.aluop = AluSltu;
        FN_SLL:  c.aluop = AluSll;
        FN_SRL:  c.aluop = AluSrl;
        FN_SRA:  c.aluop = AluSra;
        default: begin c = '0; wa = 5'd0; end
      endcase
    end else if (op == OP_ADDI || op == OP_ADDIU || op == OP_SLTI || op == OP_ANDI ||
                 op == OP_ORI || op == OP_XORI || op == OP_LUI) begin
      c.regwrite = 1'b1;
      c.alusrc   = 1'b1;
      wa = ins[20:16];
      if (op == OP_ADDI)  c.aluop = AluAdd;
      if (op == OP_ADDIU) c.aluop = AluAddu;
      if (op == OP_SLTI)  c.aluop = AluSlt;
      if (op == OP_ANDI)  begin c.aluop = AluAnd; imm = {16'h0, ins[15:0]}; end
      if (op == OP_ORI)   begin c.aluop = AluOr;  imm = {16'h0, ins[15:0]}; end
      if (op == OP_XORI)  begin c.aluop = AluXor; imm = {16'h0, ins[15:0]}; end
      if (op == OP_LUI)   begin c.aluop = AluLui; imm = {ins[15:0], 16'h0}; end
    end else if (op == OP_LW) begin
      c.regwrite = 1'b1; c.memread = 1'b1; c.alusrc = 1'b1; wa = ins[20:16];
    end else if (op == OP_SW) begin
      c.memwrite = 1'b1; c.alusrc = 1'b1; ur = 1'b1;
    end else if (op == OP_BEQ || op == OP_BNE) begin
      c.branch = 1'b1; c.branch_ne = (op == OP_BNE); c.aluop = AluSub; ur = 1'b1;
    end else if (op == OP_J) begin
      c.jump = 1'b1;
    end
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] r, input logic [31:0] rfv);
    if (r == 5'd0) return 32'h0;
    if (wb_regwrite && wb_waddr == r) return wb_wdata;
    return rfv;
  endfunction

  // Called with inputs already driven (after negedge); checks the combinational
  // outputs, advances the model one edge and queues the expected ID/EX state.
  task automatic step();
    ctrl_t       dc;
    logic [4:0]  dwa, rs, rt;
    logic [31:0] dimm;
    logic        ur, lu, expStall;
    rs = id_instr[25:21];
    rt = id_instr[20:16];
    ref_decode(id_instr, dc, dwa, dimm, ur);
    lu = id_valid && m.valid && m.ctrl.memread && (m.wa != 5'd0) &&
         ((m.wa == rs) || (ur && m.wa == rt));
    expStall = ex_hold || (lu && !ex_flush);
    #1;
    seenStall = stall_out;
    if (modelKnown) chk("stall_out", 32'(stall_out), 32'(expStall));
    chk("rf_raddr1", 32'(rf_raddr1), 32'(rs));
    chk("rf_raddr2", 32'(rf_raddr2), 32'(rt));
    if (rst) begin
      m = '0; m.pc = RST_PC; m.full = 1'b1; modelKnown = 1'b1;
    end else if (ex_hold) begin
      // unchanged
    end else if (ex_flush || lu) begin
      m = '0;
    end else begin
      m.valid = id_valid;
      m.ctrl  = id_valid ? dc : '0;
      m.pc    = id_pc;
      m.rsv   = opnd(rs, rf_rdata1);
      m.rtv   = opnd(rt, rf_rdata2);
      m.imm   = dimm;
      m.rs    = rs;
      m.rt    = rt;
      m.wa    = dwa;
      m.full  = 1'b1;
    end
    lastStall = expStall;
    if (modelKnown) sbq.push_back(m);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    fn = FN_ADD;
    case ($urandom_range(0, 15))
      0, 1, 2, 3: op = OP_RTYPE;
      4:  op = OP_ADDI;
      5:  op = OP_ADDIU;
      6:  op = OP_SLTI;
      7:  op = OP_ANDI;
      8:  op = OP_ORI;
      9:  op = OP_XORI;
      10: op = OP_LUI;
      11, 12: op = OP_LW;
      13: op = OP_SW;
      14: op = ($urandom_range(0, 1) != 0) ? OP_BEQ : OP_BNE;
      default: op = ($urandom_range(0, 1) != 0) ? OP_J : 6'h3F;
    endcase
    if (op == OP_RTYPE) begin
      case ($urandom_range(0, 12))
        0: fn = FN_ADD;  1: fn = FN_ADDU; 2: fn = FN_SUB;  3: fn = FN_SUBU;
        4: fn = FN_AND;  5: fn = FN_OR;   6: fn = FN_XOR;  7: fn = FN_NOR;
        8: fn = FN_SLT;  9: fn = FN_SLTU; 10: fn = FN_SLL; 11: fn = FN_SRL;
        default: fn = FN_SRA;
      endcase
      return {op, rs, rt, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), fn};
    end
    return {op, rs, rt, 16'($urandom)};
  endfunction

  // Monitor: one expected record per clock edge once the model is known.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("ex_valid", 32'(ex_valid), 32'(e.valid));
        chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ctrl));
        if (e.full) begin
          chk("ex_pc", ex_pc, e.pc);
          chk("ex_rs_val", ex_rs_val, e.rsv);
          chk("ex_rt_val", ex_rt_val, e.rtv);
          chk("ex_imm", ex_imm, e.imm);
          chk("ex_rs", 32'(ex_rs), 32'(e.rs));
          chk("ex_rt", 32'(ex_rt), 32'(e.rt));
          chk("ex_waddr", 32'(ex_waddr), 32'(e.wa));
        end
      end
    end
  end

  initial begin
    ctrl_t cc;
    m = '0;
    @(negedge clk);

    // Reset
    rst = 1'b1; id_valid = 1'b1; id_instr = 32'h2108_0007; id_pc = 32'h1000;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_pc", ex_pc, RST_PC);
    chk("rst_ctrl", 32'(ex_ctrl), 32'd0);

    // addi $t0,$zero,5
    id_instr = {OP_ADDI, 5'd0, 5'd8, 16'd5}; id_pc = 32'h104; rf_rdata1 = '0;
    step();
    cc = ex_ctrl;
    chk("addi_valid", 32'(ex_valid), 32'd1);
    chk("addi_imm", ex_imm, 32'd5);
    chk("addi_waddr", 32'(ex_waddr), 32'd8);
    chk("addi_regwrite", 32'(cc.regwrite), 32'd1);
    chk("addi_alusrc", 32'(cc.alusrc), 32'd1);

    // Writeback bypass: add $9,$8,$8 while WB writes $8
    id_instr = {OP_RTYPE, 5'd8, 5'd8, 5'd9, 5'd0, FN_ADD}; id_pc = 32'h108;
    rf_rdata1 = '0; rf_rdata2 = '0;
    wb_regwrite = 1'b1; wb_waddr = 5'd8; wb_wdata = 32'h1234;
    step();
    wb_regwrite = 1'b0;
    chk("byp_rs", ex_rs_val, 32'h1234);
    chk("byp_rt", ex_rt_val, 32'h1234);

    // Load-use: lw $8,0($1) then add $9,$8,$1
    id_instr = {OP_LW, 5'd1, 5'd8, 16'd0}; id_pc = 32'h10C;
    step();
    id_instr = {OP_RTYPE, 5'd8, 5'd1, 5'd9, 5'd0, FN_ADD}; id_pc = 32'h110;
    step();
    chk("lu_stall", 32'(seenStall), 32'd1);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    step();
    chk("lu_retry_stall", 32'(seenStall), 32'd0);
    chk("lu_retry_valid", 32'(ex_valid), 32'd1);
    chk("lu_retry_waddr", 32'(ex_waddr), 32'd9);

    // Load-use coinciding with a flush
    id_instr = {OP_LW, 5'd1, 5'd8, 16'd4}; id_pc = 32'h114;
    step();
    id_instr = {OP_RTYPE, 5'd8, 5'd1, 5'd9, 5'd0, FN_ADD}; id_pc = 32'h118; ex_flush = 1'b1;
    step();
    ex_flush = 1'b0;
    chk("luf_stall", 32'(seenStall), 32'd0);
    chk("luf_valid", 32'(ex_valid), 32'd0);

    // Invalid IF/ID slot
    id_valid = 1'b0; id_instr = {OP_ADDI, 5'd0, 5'd8, 16'd5};
    step();
    chk("idv0_ctrl", 32'(ex_ctrl), 32'd0);
    chk("idv0_valid", 32'(ex_valid), 32'd0);
    id_valid = 1'b1;

    // Hold for 3 cycles with a flush pulse in the middle
    id_instr = {OP_ADDI, 5'd0, 5'd8, 16'd5}; id_pc = 32'h11C;
    step();
    id_instr = {OP_ORI, 5'd2, 5'd3, 16'h8001};
    ex_hold = 1'b1;
    step(); chk("hold_stall0", 32'(seenStall), 32'd1);
    ex_flush = 1'b1;
    step(); chk("hold_stall1", 32'(seenStall), 32'd1);
    ex_flush = 1'b0;
    step(); chk("hold_stall2", 32'(seenStall), 32'd1);
    ex_hold = 1'b0;
    chk("hold_valid", 32'(ex_valid), 32'd1);
    chk("hold_imm", ex_imm, 32'd5);

    // $0 reads zero even when WB targets it
    id_instr = {OP_RTYPE, 5'd0, 5'd0, 5'd9, 5'd0, FN_ADD}; id_pc = 32'h120;
    rf_rdata1 = 32'hFFFF_FFFF; rf_rdata2 = 32'hFFFF_FFFF;
    wb_regwrite = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFF_FFFF;
    step();
    wb_regwrite = 1'b0;
    chk("zero_rs", ex_rs_val, 32'h0);
    chk("zero_rt", ex_rt_val, 32'h0);

    // Undefined opcode
    id_instr = {6'h3F, 5'd3, 5'd4, 16'h1234};
    step();
    chk("undef_ctrl", 32'(ex_ctrl), 32'd0);
    chk("undef_waddr", 32'(ex_waddr), 32'd0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      ex_hold  = ($urandom_range(0, 7) == 0);
      ex_flush = ($urandom_range(0, 7) == 0);
      if (!lastStall) begin
        id_instr = rand_instr();
        id_valid = ($urandom_range(0, 7) != 0);
        id_pc    = $urandom & 32'hFFFF_FFFC;
      end
      rf_rdata1   = $urandom;
      rf_rdata2   = $urandom;
      wb_regwrite = ($urandom_range(0, 1) != 0);
      wb_waddr    = ($urandom_range(0, 1) != 0) ? id_instr[25:21] : 5'($urandom_range(0, 7));
      wb_wdata    = $urandom;
      step();
    end
    rst = 1'b0; ex_hold = 1'b0; ex_flush = 1'b0;

    @(posedge clk);
    #2;
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/operand stage of the 5-stage MIPS pipeline. It sits between the IF/ID register and EX.
- Drives the register file read addresses from the fetched instruction and bypasses the same-cycle writeback value.
- Decodes control, sign-extends the immediate, detects load-use hazards and holds the ID/EX pipeline register (stall, bubble, flush).

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, value of ex_pc after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_instr  in  32  instruction from IF/ID.
- id_pc  in  XLEN  PC+4 of that instruction.
- rf_raddr1  out  5  rs field, to register file read port 1 (combinational).
- rf_raddr2  out  5  rt field, to register file read port 2 (combinational).
- rf_rdata1  in  XLEN  register file read data 1.
- rf_rdata2  in  XLEN  register file read data 2.
- wb_regwrite  in  1  writeback write enable (same signal feeding the register file).
- wb_waddr  in  5  writeback destination register.
- wb_wdata  in  XLEN  writeback data.
- ex_hold  in  1  EX cannot accept; ID/EX keeps its contents.
- ex_flush  in  1  taken branch resolved in EX; squash the instruction currently in ID.
- stall_out  out  1  hold PC and IF/ID (combinational).
- ex_valid  out  1  ID/EX holds a valid instruction.
- ex_pc  out  XLEN  registered PC+4.
- ex_rs_val, ex_rt_val  out  XLEN  registered operands.
- ex_imm  out  XLEN  registered sign/zero-extended immediate.
- ex_rs, ex_rt, ex_waddr  out  5 each  registered register numbers; ex_waddr is the destination.
- ex_ctrl  out  CTRL_W  registered control bundle.

Behaviour:
- Decoded opcodes:
  - R-type (add/addu/sub/subu/and/or/xor/nor/slt/sltu/sll/srl/sra).
  - Immediate: addi, addiu, andi, ori, xori, slti, lui.
  - Memory: lw, sw.
  - Branch/jump: beq, bne, j.
- Any other opcode decodes as a NOP: ctrl all zero.
- ex_waddr: rd for R-type, rt for I-type loads/ALU ops, 0 otherwise.
- ex_imm: zero-extended for andi/ori/xori; imm<<16 for lui; sign-extended for all others.
- WB bypass on each operand:
  - If wb_regwrite && wb_waddr!=0 && wb_waddr==rs, the rs operand is wb_wdata; otherwise it is rf_rdata1.
  - Same rule for rt using rf_rdata2.
  - Register 0 always reads 0.
- uses_rt is true for R-type, sw, beq, bne.
- Load-use hazard (lu) = id_valid && ex_valid && ex_ctrl.memread && ex_waddr!=0 && (ex_waddr==rs || (uses_rt && ex_waddr==rt)).
- stall_out = ex_hold || (lu && !ex_flush).
- ID/EX update priority at posedge:
  1. rst: ex_valid=0, ctrl=0, all data/address fields=0, ex_pc=RESET_PC.
  2. ex_hold: all fields unchanged. A simultaneous ex_flush is ignored; EX re-asserts it after hold drops.
  3. ex_flush: bubble (ex_valid=0, ctrl=0, data fields don't-care but held at 0).
  4. lu: bubble; the IF/ID instruction stays and retries next cycle.
  5. otherwise: load the decoded instruction, with ex_valid=id_valid. ctrl is forced to 0 when id_valid=0.
- Latency: one cycle from IF/ID to ID/EX. Operands are captured after the bypass.
- Reset mid-stall clears the stage; stall_out is combinational and drops with ex_valid=0.

Decomposition:
- Package mips_pkg holds:
  - Opcode/funct constants.
  - The ctrl_t struct: regwrite, memread, memwrite, alusrc, branch, branch_ne, jump, aluop[3:0].
  - CTRL_W.
- Sub-module id_ctrl_dec: purely combinational opcode/funct to ctrl_t, waddr select and immediate mode.
- The stage module contains the bypass, hazard logic and ID/EX register.

Test Plan:
- Reset, then addi $t0,$zero,5 with rf_rdata1=0 -> next cycle ex_valid=1, ex_imm=5, ex_waddr=8, ctrl.regwrite=1, alusrc=1.
- WB writes $8=0x1234 while ID holds add $9,$8,$8 with rf_rdata=old 0 -> ex_rs_val=ex_rt_val=0x1234.
- lw $8 in EX, add $9,$8,$1 in ID -> stall_out=1 for one cycle with ex_valid=0 bubble; next cycle the add is loaded.
- Load-use stall while ex_flush=1 -> stall_out=0, ex_valid=0; id_valid=0 case -> ctrl=0.
- ex_hold=1 for 3 cycles with ex_flush pulsed -> ID/EX unchanged and stall_out=1 throughout; flush has no effect.
- WB write to $0 with data 0xFFFF_FFFF while ID reads $0 -> operand 0. Undefined opcode 0x3F -> ctrl=0, ex_waddr=0.
